// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking-lot occupancy controller.
//   state_t     : direction FSM state encoding (3-bit)
//   bcd_t       : one BCD digit
//   count_t     : four BCD digits, index 0 = units
//   SENSOR_IDLE : debounced {a,b} pattern with both beams clear
//   bcd_inc/dec : single-step decimal increment/decrement across digits
//   to_bcd      : integer to count_t, evaluated at elaboration time
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EN1,
    ST_EN2,
    ST_EN3,
    ST_EX1,
    ST_EX2,
    ST_EX3,
    ST_WAIT
  } state_t;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [3:0] count_t;

  localparam logic [1:0] SENSOR_IDLE = 2'b00;

  function automatic count_t bcd_inc(input count_t c);
    count_t r;
    logic   carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic count_t bcd_dec(input count_t c);
    count_t r;
    logic   borrow;
    r      = c;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i] == 4'd0) begin
          r[i] = 4'd9;
        end else begin
          r[i]   = r[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic count_t to_bcd(input int v);
    count_t r;
    int     t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i] = bcd_t'(t % 10);
      t    = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Sensor/display bundle of the parking-lot controller.
//   a, b, clr        : raw outer/inner beam sensors and synchronous count clear
//   dig0..dig3       : BCD occupancy digits (dig0 = units)
//   blank            : leading-zero blank mask, bit i blanks dig<i>
//   enter_p, exit_p  : one-cycle completion pulses
//   full, empty      : occupancy status
// master = sensor/display side, slave = controller side.
interface parking_lot_ctrl_if;
  import parking_pkg::*;

  logic       a;
  logic       b;
  logic       clr;
  bcd_t       dig0;
  bcd_t       dig1;
  bcd_t       dig2;
  bcd_t       dig3;
  logic [3:0] blank;
  logic       enter_p;
  logic       exit_p;
  logic       full;
  logic       empty;

  modport master (
    output a, b, clr,
    input  dig0, dig1, dig2, dig3, blank, enter_p, exit_p, full, empty
  );

  modport slave (
    input  a, b, clr,
    output dig0, dig1, dig2, dig3, blank, enter_p, exit_p, full, empty
  );

endinterface

// File: rtl/parking_lot_ctrl_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer for one beam sensor.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous sensor input
//   deb        : debounced level; follows raw once the synchronized value has
//                differed from it for DB_CYCLES consecutive cycles, i.e.
//                DB_CYCLES+2 edges after a clean raw change
module debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] run;

  // NOTE: every flop here and in the top is cleared asynchronously and
  // assigned with <= so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      run  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) begin
        // Any reversion restarts the run.
        run <= '0;
      end else if (run == CW'(DB_CYCLES - 1)) begin
        // This sample is the DB_CYCLES-th consecutive difference.
        deb <= sync[1];
        run <= '0;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking-lot occupancy controller: conditions the two beam sensors, decodes
// entry (00-10-11-01-00) and exit (00-01-11-10-00) sequences, and keeps a
// saturating 4-digit BCD occupancy count for the 7-segment display path.
//   clk   : system clock
//   reset : asynchronous assert, synchronously released, active-low reset
//   bus   : sensor inputs, clear, digits, blank mask, pulses and status
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int CAPACITY  = 9999
) (
  input  logic             clk,
  input  logic             reset,
  parking_lot_ctrl_if.slave bus
);

  localparam count_t CAP_BCD = to_bcd(CAPACITY);

  // Reset asserts immediately but releases only after two clean edges.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Sensor conditioning
  logic a_db;
  logic b_db;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.a),
    .deb   (a_db)
  );

  debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.b),
    .deb   (b_db)
  );

  // Direction FSM with registered completion pulses. In each sequence state
  // the pattern that led into it is its hold pattern; anything unexpected,
  // including both beams changing together, parks the FSM in ST_WAIT until
  // the lot entrance is clear again.
  logic [1:0] ab;
  state_t     state;
  logic       enter_p;
  logic       exit_p;

  assign ab = {a_db, b_db};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      enter_p <= 1'b0;
      exit_p  <= 1'b0;
    end else begin
      enter_p <= 1'b0;
      exit_p  <= 1'b0;
      case (state)
        ST_IDLE:
          case (ab)
            SENSOR_IDLE: state <= ST_IDLE;
            2'b10:       state <= ST_EN1;
            2'b01:       state <= ST_EX1;
            default:     state <= ST_WAIT;
          endcase
        ST_EN1:
          case (ab)
            2'b10:       state <= ST_EN1;
            2'b11:       state <= ST_EN2;
            SENSOR_IDLE: state <= ST_IDLE;
            default:     state <= ST_WAIT;
          endcase
        ST_EN2:
          case (ab)
            2'b11:   state <= ST_EN2;
            2'b01:   state <= ST_EN3;
            2'b10:   state <= ST_EN1;
            default: state <= ST_WAIT;
          endcase
        ST_EN3:
          case (ab)
            2'b01: state <= ST_EN3;
            SENSOR_IDLE: begin
              state   <= ST_IDLE;
              enter_p <= 1'b1;
            end
            2'b11:   state <= ST_EN2;
            default: state <= ST_WAIT;
          endcase
        ST_EX1:
          case (ab)
            2'b01:       state <= ST_EX1;
            2'b11:       state <= ST_EX2;
            SENSOR_IDLE: state <= ST_IDLE;
            default:     state <= ST_WAIT;
          endcase
        ST_EX2:
          case (ab)
            2'b11:   state <= ST_EX2;
            2'b10:   state <= ST_EX3;
            2'b01:   state <= ST_EX1;
            default: state <= ST_WAIT;
          endcase
        ST_EX3:
          case (ab)
            2'b10: state <= ST_EX3;
            SENSOR_IDLE: begin
              state  <= ST_IDLE;
              exit_p <= 1'b1;
            end
            2'b11:   state <= ST_EX2;
            default: state <= ST_WAIT;
          endcase
        ST_WAIT:
          if (ab == SENSOR_IDLE) state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

  // Saturating BCD occupancy count; clear dominates any pulse.
  count_t count;
  logic   full;
  logic   empty;

  assign full  = (count == CAP_BCD);
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (bus.clr) begin
      count <= '0;
    end else if (enter_p && !full) begin
      count <= bcd_inc(count);
    end else if (exit_p && !empty) begin
      count <= bcd_dec(count);
    end
  end

  // Outputs: units digit is never blanked so an empty lot shows "0".
  assign bus.dig0     = count[0];
  assign bus.dig1     = count[1];
  assign bus.dig2     = count[2];
  assign bus.dig3     = count[3];
  assign bus.blank[3] = (count[3] == 4'd0);
  assign bus.blank[2] = (count[3] == 4'd0) && (count[2] == 4'd0);
  assign bus.blank[1] = (count[3] == 4'd0) && (count[2] == 4'd0) && (count[1] == 4'd0);
  assign bus.blank[0] = 1'b0;
  assign bus.enter_p  = enter_p;
  assign bus.exit_p   = exit_p;
  assign bus.full     = full;
  assign bus.empty    = empty;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl with DB_CYCLES=4, CAPACITY=100.
module tb_parking_lot_ctrl;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_enter = 0;
  int   n_exit = 0;
  int   exp_enter = 0;
  int   exp_exit = 0;

  parking_lot_ctrl_if bus ();

  parking_lot_ctrl #(.DB_CYCLES(4), .CAPACITY(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts every cycle the pulses are high.
  always @(posedge clk) begin
    if (bus.enter_p) n_enter++;
    if (bus.exit_p)  n_exit++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ab);
    @(negedge clk);
    bus.a = ab[1];
    bus.b = ab[0];
    repeat (10) @(negedge clk);
  endtask

  task automatic do_entry();
    drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
  endtask

  task automatic do_exit();
    drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
  endtask

  function automatic logic [15:0] digits();
    return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
  endfunction

  initial begin
    logic seen;
    bus.a = 1'b0; bus.b = 1'b0; bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    // Reset state
    check("rst_digits", 32'(digits()), 32'h0000);
    check("rst_blank", 32'(bus.blank), 32'b1110);
    check("rst_enter_p", 32'(bus.enter_p), 32'd0);
    check("rst_exit_p", 32'(bus.exit_p), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);

    // Entry
    do_entry(); exp_enter++;
    check("entry_pulses", 32'(n_enter), 32'(exp_enter));
    check("entry_digits", 32'(digits()), 32'h0001);
    check("entry_blank", 32'(bus.blank), 32'b1110);
    check("entry_empty", 32'(bus.empty), 32'd0);

    // Exit, then exit at the floor, then abort
    do_exit(); exp_exit++;
    check("exit_pulses", 32'(n_exit), 32'(exp_exit));
    check("exit_digits", 32'(digits()), 32'h0000);
    check("exit_empty", 32'(bus.empty), 32'd1);
    do_exit(); exp_exit++;
    check("floor_pulses", 32'(n_exit), 32'(exp_exit));
    check("floor_digits", 32'(digits()), 32'h0000);
    drive(2'b10); drive(2'b00);
    check("abort_enter", 32'(n_enter), 32'(exp_enter));
    check("abort_exit", 32'(n_exit), 32'(exp_exit));
    check("abort_digits", 32'(digits()), 32'h0000);

    // Bounce on a: never stable long enough to pass the debouncer
    for (int i = 0; i < 20; i++) begin
      bus.a = ~bus.a;
      repeat (2) @(negedge clk);
      if (i % 5 == 4) check("bounce_a_db", 32'(dut.a_db), 32'd0);
    end
    repeat (10) @(negedge clk);
    check("bounce_state", 32'(dut.state), 32'(ST_IDLE));
    check("bounce_enter", 32'(n_enter), 32'(exp_enter));
    check("bounce_exit", 32'(n_exit), 32'(exp_exit));

    // Illegal simultaneous change
    drive(2'b11);
    check("illegal_state", 32'(dut.state), 32'(ST_WAIT));
    drive(2'b10);
    check("illegal_hold", 32'(dut.state), 32'(ST_WAIT));
    drive(2'b00);
    check("illegal_idle", 32'(dut.state), 32'(ST_IDLE));
    check("illegal_enter", 32'(n_enter), 32'(exp_enter));
    check("illegal_digits", 32'(digits()), 32'h0000);

    // Carry and saturation at CAPACITY=100
    for (int i = 0; i < 99; i++) do_entry();
    exp_enter += 99;
    check("pre_digits", 32'(digits()), 32'h0099);
    check("pre_blank", 32'(bus.blank), 32'b1100);
    check("pre_full", 32'(bus.full), 32'd0);
    do_entry(); exp_enter++;
    check("carry_digits", 32'(digits()), 32'h0100);
    check("carry_full", 32'(bus.full), 32'd1);
    check("carry_blank", 32'(bus.blank), 32'b1000);
    do_entry(); exp_enter++;
    check("sat_pulses", 32'(n_enter), 32'(exp_enter));
    check("sat_digits", 32'(digits()), 32'h0100);

    // Clear alone, then clear coincident with an entry pulse
    @(negedge clk); bus.clr = 1'b1;
    @(negedge clk); bus.clr = 1'b0;
    check("clr_digits", 32'(digits()), 32'h0000);
    for (int i = 0; i < 5; i++) do_entry();
    exp_enter += 5;
    check("five_digits", 32'(digits()), 32'h0005);
    drive(2'b10); drive(2'b11); drive(2'b01);
    @(negedge clk);
    bus.a = 1'b0; bus.b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.enter_p) seen = 1'b1;
    end
    check("clr_pulse_seen", 32'(seen), 32'd1);
    bus.clr = 1'b1;
    @(negedge clk); bus.clr = 1'b0;
    exp_enter++;
    repeat (3) @(negedge clk);
    check("clr_prio_digits", 32'(digits()), 32'h0000);
    check("clr_prio_pulses", 32'(n_enter), 32'(exp_enter));

    // Reset in EN2
    do_entry(); exp_enter++;
    check("pre_rst_digits", 32'(digits()), 32'h0001);
    drive(2'b10); drive(2'b11);
    check("en2_state", 32'(dut.state), 32'(ST_EN2));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_digits", 32'(digits()), 32'h0000);
    check("mid_rst_blank", 32'(bus.blank), 32'b1110);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    bus.a = 1'b0; bus.b = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_enter", 32'(n_enter), 32'(exp_enter));
    do_entry(); exp_enter++;
    check("post_rst_digits", 32'(digits()), 32'h0001);
    check("post_rst_pulses", 32'(n_enter), 32'(exp_enter));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Occupancy controller for the parking-meter display path. Conditions the two raw beam sensors `a` (outer) and `b` (inner), decodes complete vehicle entry/exit sequences with a direction state machine, and maintains a saturating 4-digit BCD occupancy count. Its outputs are the per-digit hex values and leading-zero blank mask that feed the seven-segment converter and the 4-digit display multiplexer, plus status flags.

## Interface
- `DB_CYCLES`, default 500000: stable-sample count for debounce (10 ms at 50 MHz); legal range 2..2^20.
- `CAPACITY`, default 9999: lot capacity; legal range 1..9999.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `a`  in  1  raw outer sensor, 1 = beam blocked; asynchronous to `clk`.
- `b`  in  1  raw inner sensor, 1 = beam blocked; asynchronous to `clk`.
- `clr`  in  1  synchronous count clear, active-high.
- `dig0`..`dig3`  out  4 each  BCD occupancy digits; `dig0` = units.
- `blank`  out  4  per-digit blank mask (bit i blanks `dig<i>`).
- `enter_p`  out  1  one-cycle pulse when an entry sequence completes.
- `exit_p`  out  1  one-cycle pulse when an exit sequence completes.
- `full`  out  1  count == `CAPACITY`.
- `empty`  out  1  count == 0.

## Operation
- Conditioning: each of `a` and `b` passes through a 2-FF synchronizer, then a debouncer. The debounced value takes the synchronized value once that value has differed from the debounced value for `DB_CYCLES` consecutive cycles. Any reversion before that restarts the run counter.
- Direction FSM on debounced pair `{a,b}`. States: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT.
  - IDLE: 10→EN1; 01→EX1; 11→WAIT; 00 stays.
  - EN1: 11→EN2; 00→IDLE (abort).
  - EN2: 01→EN3; 10→EN1.
  - EN3: 00→IDLE with `enter_p`; 11→EN2.
  - EX1: 11→EX2; 00→IDLE.
  - EX2: 10→EX3; 01→EX1.
  - EX3: 00→IDLE with `exit_p`; 11→EX2.
  - Any pattern not listed (including both bits changing in the same cycle) →WAIT.
  - WAIT: 00→IDLE; otherwise stays. WAIT never pulses.
- Counter (4 BCD digits, decimal carry/borrow per digit), evaluated in priority order:
  - `clr` forces the count to 0000.
  - else `enter_p` increments the count unless it is already `full`. A saturated entry still pulses but does not count.
  - else `exit_p` decrements the count unless it is already `empty`.
  - `enter_p` and `exit_p` are mutually exclusive by construction.
- Blank: bit i = 1 when `dig<i>` and every higher digit are 0, for i = 1..3. Bit 0 is always 0, so "0" displays.

## Timing
- Reset (async assert, sync release): synchronizers and debouncers 0, FSM IDLE, count 0000, `blank`=1110, `enter_p`=`exit_p`=0, `full`=0, `empty`=1.
- Debounced bit changes exactly `DB_CYCLES`+2 rising edges after a raw change that is held stable.
- `enter_p`/`exit_p` are registered: asserted the cycle after the FSM samples 00 in EN3/EX3.
- Count, digits, `blank`, `full` and `empty` all update on the edge after the pulse cycle (1-cycle latency).
- `clr` takes effect on the next edge; `clr` in the same cycle as a pulse yields 0000.
- Wrap-around never occurs: 9999 or `CAPACITY` saturates, 0000 floors.
- Reset asserted mid-sequence abandons the sequence without a pulse.

## Structure
- Package `parking_pkg`:
  - FSM state enum (3-bit).
  - BCD digit type (4-bit).
  - Count vector type (4×BCD).
  - `SENSOR_IDLE`=2'b00 constant.
- Sub-module `debounce` (synchronizer + run counter, parameter `DB_CYCLES`), instantiated once for `a` and once for `b`.
- FSM and BCD counter live in the top of this block.

## Test plan
- Entry: with `DB_CYCLES`=4, drive `{a,b}` 00→10→11→01→00, each held 10 cycles. Expect one `enter_p`, count 0001, digits 0,0,0,1, `blank`=1110, `empty`=0.
- Exit and abort: from count 0001, drive 00→01→11→10→00. Expect `exit_p` and count 0000. Then drive 10→00. Expect no pulse.
- Bounce: toggle `a` every 2 cycles for 40 cycles. Expect debounced `a` unchanged and no pulses.
- Carry and saturation: with `CAPACITY`=100 and count preloaded to 0099 via entries, one entry gives 0100, `full`=1, `blank`=1000. A further entry pulses `enter_p` and the count stays 0100.
- Illegal sequence: 00→11 (simultaneous). Expect WAIT and no pulse. Then 10→00 returns to IDLE with the count unchanged.
- Priority and reset: `clr` coincident with `enter_p` at count 0005 gives 0000. Asserting `reset` low while in EN2 gives all outputs at reset values immediately, and the next full sequence counts normally.
